// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// MIPS load/store op codes, bus size codes, FSM state encoding and small
// op-classification helpers used by the controller and the lane aligner.
package dmem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic addr_misaligned(input logic [7:0] op, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: mis = lane[0];
      EXE_LW_OP, EXE_SW_OP:             mis = |lane;
      default:                          mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// SRAM-like data bus between the access controller (master) and the
// memory agent (slave).
//   data_req/wr/size/addr/wdata/wstrb : request fields, master -> slave
//   data_addr_ok                      : request accepted, slave -> master
//   data_data_ok/data_rdata           : response and read data, slave -> master
interface dmem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl_mem_lane_align.sv
// Combinational byte-lane handling for one access.
//   op_i, lane_i : op code and address[1:0] of the access
//   wdata_i      : store source value
//   rdata_i      : raw bus read data
//   size_o       : bus size code
//   wstrb_o      : byte write strobes (zero for loads)
//   wdata_o      : store data replicated across lanes
//   rdata_o      : selected and sign/zero-extended load data
module mem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [1:0]  size_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    size_o  = SIZE_B;
    wstrb_o = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    case (op_i)
      EXE_LB_OP:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: rdata_o = {24'd0, byte_sel};
      EXE_LH_OP: begin
        size_o  = SIZE_H;
        rdata_o = {{16{half_sel[15]}}, half_sel};
      end
      EXE_LHU_OP: begin
        size_o  = SIZE_H;
        rdata_o = {16'd0, half_sel};
      end
      EXE_LW_OP: begin
        size_o  = SIZE_W;
        rdata_o = rdata_i;
      end
      EXE_SB_OP: begin
        wstrb_o = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      EXE_SH_OP: begin
        size_o  = SIZE_H;
        wstrb_o = 4'b0011 << lane_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      EXE_SW_OP: begin
        size_o  = SIZE_W;
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment exceptions, bus
// sequencing with pipeline stall, and extended load data for writeback.
//   clk, rst                     : clock, synchronous active-high reset
//   mem_en, alucontrolM, addrM,
//   wdataM, flushM, hold         : MEM-stage request and pipeline control
//   stallM, rdataM, done_o       : stall, load result, result-valid strobe
//   adelM, adesM, badvaddrM      : address-error flags and faulting address
//   bus                          : data bus master port
//
// state | meaning
// IDLE  | no access in flight; accepts an aligned, unflushed load/store
// REQ   | data_req held until the agent accepts (addr_ok)
// WAIT  | request accepted, waiting for data_ok
// DONE  | result valid on rdataM/done_o; held while hold=1
// DRAIN | flushed access still outstanding; swallow its data_ok
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [7:0]  alucontrolM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        flushM,
  input  logic        hold,
  output logic        stallM,
  output logic [31:0] rdataM,
  output logic        done_o,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] badvaddrM,
  dmem_access_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic [7:0]  op_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] rdata_ext, wdata_rep;
  logic [3:0]  wstrb;
  logic [1:0]  size;
  logic        misaligned, accept, capture;

  assign misaligned = addr_misaligned(alucontrolM, addrM[1:0]);
  assign adelM      = mem_en & misaligned & is_load(alucontrolM);
  assign adesM      = mem_en & misaligned & is_store(alucontrolM);
  assign badvaddrM  = addrM;

  // Bus fields come from the latched op so they stay stable while REQ waits.
  mem_lane_align u_lane (
    .op_i    (op_q),
    .lane_i  (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus.data_rdata),
    .size_o  (size),
    .wstrb_o (wstrb),
    .wdata_o (wdata_rep),
    .rdata_o (rdata_ext)
  );

  assign bus.data_wr    = is_store(op_q);
  assign bus.data_size  = size;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_rep;
  assign bus.data_wstrb = wstrb;
  assign rdataM         = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= alucontrolM;
        addr_q  <= addrM;
        wdata_q <= wdataM;
      end
      if (capture) rdata_q <= rdata_ext;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture      = 1'b0;
    stallM       = 1'b0;
    done_o       = 1'b0;
    bus.data_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_en && (is_load(alucontrolM) || is_store(alucontrolM)) &&
            !misaligned && !flushM) begin
          accept  = 1'b1;
          stallM  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stallM       = 1'b1;
        bus.data_req = 1'b1;
        if (bus.data_addr_ok) begin
          // Once issued, a flushed access must still have its response absorbed.
          if (bus.data_data_ok) begin
            if (flushM) state_d = S_IDLE;
            else begin
              state_d = S_DONE;
              capture = is_load(op_q);
            end
          end else begin
            state_d = flushM ? S_DRAIN : S_WAIT;
          end
        end else if (flushM) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stallM = 1'b1;
        if (bus.data_data_ok) begin
          if (flushM) state_d = S_IDLE;
          else begin
            state_d = S_DONE;
            capture = is_load(op_q);
          end
        end else if (flushM) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.data_data_ok) state_d = S_IDLE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (!hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, mem_en, flushM, hold;
  logic [7:0]  alucontrolM;
  logic [31:0] addrM, wdataM;
  logic        stallM, done_o, adelM, adesM;
  logic [31:0] rdataM, badvaddrM;

  dmem_access_ctrl_if bus_if();

  dmem_access_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en      (mem_en),
    .alucontrolM (alucontrolM),
    .addrM       (addrM),
    .wdataM      (wdataM),
    .flushM      (flushM),
    .hold        (hold),
    .stallM      (stallM),
    .rdataM      (rdataM),
    .done_o      (done_o),
    .adelM       (adelM),
    .adesM       (adesM),
    .badvaddrM   (badvaddrM),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // expectations for the current cycle, written just after each rising edge
  logic        e_stall, e_done, e_req, e_zero, e_wr;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata, e_rdata;

  // ---------------- reference model (op table + lane arithmetic) ----------
  function automatic logic [7:0] code_of(input int oi);
    case (oi)
      0: return EXE_LB_OP;
      1: return EXE_LBU_OP;
      2: return EXE_LH_OP;
      3: return EXE_LHU_OP;
      4: return EXE_LW_OP;
      5: return EXE_SB_OP;
      6: return EXE_SH_OP;
      default: return EXE_SW_OP;
    endcase
  endfunction

  function automatic int nb_of(input int oi);
    case (oi)
      0, 1, 5: return 1;
      2, 3, 6: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_ld(input int oi);
    return oi < 5;
  endfunction

  function automatic bit is_sg(input int oi);
    return (oi == 0) || (oi == 2);
  endfunction

  function automatic int idx_of(input logic [7:0] op);
    for (int i = 0; i < 8; i++) if (code_of(i) == op) return i;
    return -1;
  endfunction

  function automatic logic [1:0] size_ref(input int oi);
    int nb = nb_of(oi);
    return (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [3:0] wstrb_ref(input int oi, input logic [31:0] addr);
    int s;
    if (is_ld(oi)) return 4'b0000;
    s = ((1 << nb_of(oi)) - 1) << int'(addr[1:0]);
    return s[3:0];
  endfunction

  function automatic logic [31:0] wdata_ref(input int oi, input logic [31:0] w);
    int nb = nb_of(oi);
    if (nb == 1) return {24'd0, w[7:0]} * 32'h0101_0101;
    if (nb == 2) return {16'd0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] ext_ref(input int oi, input logic [31:0] addr,
                                          input logic [31:0] rd);
    int nb = nb_of(oi);
    logic [31:0] v, mask;
    if (nb == 4) return rd;
    v    = rd >> (8 * int'(addr[1:0]));
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = v & mask;
    if (is_sg(oi) && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] align_addr(input int oi);
    logic [31:0] r = $urandom;
    return r - (r % nb_of(oi));
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  int   c_oi;
  logic c_mis;

  always @(negedge clk) begin
    if (chk_en) begin
      c_oi  = idx_of(alucontrolM);
      c_mis = (c_oi >= 0) && ((int'(addrM[1:0]) % nb_of(c_oi)) != 0);
      chk("adelM", adelM, mem_en && c_mis && is_ld(c_oi));
      chk("adesM", adesM, mem_en && c_mis && !is_ld(c_oi));
      chk("badvaddrM", badvaddrM, addrM);
      chk("stallM", stallM, e_stall);
      chk("done_o", done_o, e_done);
      chk("data_req", bus_if.data_req, e_req);
      chk("rdataM", rdataM, e_rdata);
      if (e_req) begin
        chk("data_wr", bus_if.data_wr, e_wr);
        chk("data_size", bus_if.data_size, e_size);
        chk("data_addr", bus_if.data_addr, e_addr);
        chk("data_wstrb", bus_if.data_wstrb, e_wstrb);
        if (e_wr) chk("data_wdata", bus_if.data_wdata, e_wdata);
      end
      if (e_zero) begin
        chk("rst_wr", bus_if.data_wr, 0);
        chk("rst_size", bus_if.data_size, 0);
        chk("rst_addr", bus_if.data_addr, 0);
        chk("rst_wdata", bus_if.data_wdata, 0);
        chk("rst_wstrb", bus_if.data_wstrb, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access from acceptance to completion. a = REQ cycles before addr_ok,
  // d = cycles from addr_ok to data_ok, h = hold cycles in DONE.
  // fmode 1: flush in REQ cycle fat (no addr_ok). fmode 2: flush in WAIT
  // cycle fat, then present a LW at daddr while the old access drains.
  task automatic access(input int oi, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int a, input int d, input int h,
                        input int fmode, input int fat, input logic [31:0] daddr,
                        output logic [31:0] o_rdata, output logic [3:0] o_wstrb,
                        output logic [31:0] o_wdata, output logic [1:0] o_size,
                        output logic o_wr);
    logic [31:0] resp;
    o_rdata = '0; o_wstrb = '0; o_wdata = '0; o_size = '0; o_wr = 1'b0; resp = '0;
    mem_en = 1'b1; alucontrolM = code_of(oi); addrM = addr; wdataM = wd;
    flushM = 1'b0; hold = 1'b0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = $urandom;
    e_stall = 1'b1; e_req = 1'b0; e_done = 1'b0;
    step();
    e_wr = !is_ld(oi); e_size = size_ref(oi); e_addr = addr;
    e_wdata = wdata_ref(oi, wd); e_wstrb = wstrb_ref(oi, addr);
    for (int i = 0; i <= a; i++) begin
      e_stall = 1'b1; e_req = 1'b1;
      bus_if.data_rdata = $urandom;
      if (i == 0) begin
        o_wstrb = bus_if.data_wstrb; o_wdata = bus_if.data_wdata;
        o_size  = bus_if.data_size;  o_wr    = bus_if.data_wr;
      end
      if (fmode == 1 && i == fat) begin
        flushM = 1'b1; bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
        step();
        flushM = 1'b0; mem_en = 1'b0; e_stall = 1'b0; e_req = 1'b0;
        return;
      end
      bus_if.data_addr_ok = (i == a);
      bus_if.data_data_ok = (i == a) && (d == 0);
      if (bus_if.data_data_ok) begin bus_if.data_rdata = rd; resp = rd; end
      step();
    end
    bus_if.data_addr_ok = 1'b0;
    for (int j = 1; j <= d; j++) begin
      e_stall = 1'b1; e_req = 1'b0;
      bus_if.data_data_ok = 1'b0; bus_if.data_rdata = $urandom;
      if (fmode == 2 && j == fat) begin
        flushM = 1'b1;
        step();
        flushM = 1'b0; e_stall = 1'b0;
        mem_en = 1'b1; alucontrolM = EXE_LW_OP; addrM = daddr; wdataM = $urandom;
        for (int k = j + 1; k <= d; k++) begin
          bus_if.data_data_ok = (k == d);
          bus_if.data_rdata   = (k == d) ? rd : $urandom;
          step();
        end
        bus_if.data_data_ok = 1'b0;
        return;
      end
      bus_if.data_data_ok = (j == d);
      if (j == d) begin bus_if.data_rdata = rd; resp = rd; end
      step();
    end
    bus_if.data_data_ok = 1'b0;
    mem_en = 1'b0; alucontrolM = code_of($urandom_range(0, 7)); addrM = $urandom;
    if (is_ld(oi)) e_rdata = ext_ref(oi, addr, resp);
    for (int k = 0; k <= h; k++) begin
      e_stall = 1'b0; e_req = 1'b0; e_done = 1'b1;
      hold = (k < h);
      bus_if.data_rdata = $urandom;
      if (k == 0) o_rdata = rdataM;
      step();
    end
    hold = 1'b0; e_done = 1'b0;
  endtask

  // Cycles in which nothing may be accepted: idle, misaligned, or flushed.
  task automatic idle(input int n);
    int mode, oi;
    for (int c = 0; c < n; c++) begin
      mode = $urandom_range(0, 2);
      flushM = 1'b0;
      bus_if.data_rdata = $urandom;
      if (mode == 0) begin
        mem_en = 1'b0; oi = $urandom_range(0, 7);
        alucontrolM = code_of(oi); addrM = $urandom;
      end else if (mode == 1) begin
        case ($urandom_range(0, 4))
          0: oi = 2; 1: oi = 3; 2: oi = 4; 3: oi = 6; default: oi = 7;
        endcase
        alucontrolM = code_of(oi);
        addrM = align_addr(oi) + ((nb_of(oi) == 2) ? 32'd1 : 32'($urandom_range(1, 3)));
        mem_en = 1'b1;
      end else begin
        oi = $urandom_range(0, 7);
        alucontrolM = code_of(oi); addrM = align_addr(oi);
        mem_en = 1'b1; flushM = 1'b1;
      end
      wdataM = $urandom;
      e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0;
      step();
    end
    flushM = 1'b0; mem_en = 1'b0;
  endtask

  task automatic reset_in_req();
    mem_en = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h0000_7000; wdataM = $urandom;
    e_stall = 1'b1; e_req = 1'b0; e_done = 1'b0;
    step();
    e_stall = 1'b1; e_req = 1'b1; e_wr = 1'b0; e_size = 2'd2;
    e_addr = 32'h0000_7000; e_wstrb = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0; mem_en = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_zero = 1'b1; e_rdata = '0;
    step();
    e_zero = 1'b0;
  endtask

  logic [31:0] r_rdata, r_wdata, daddr;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_size;
  logic        r_wr;

  initial begin
    int oi, a, d, h, fmode, fat, r;
    rst = 1'b1; mem_en = 1'b0; alucontrolM = '0; addrM = '0; wdataM = '0;
    flushM = 1'b0; hold = 1'b0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0;
    e_stall = 1'b0; e_done = 1'b0; e_req = 1'b0; e_zero = 1'b1; e_wr = 1'b0;
    e_size = '0; e_wstrb = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();
    e_zero = 1'b0;

    // LW: addr_ok one cycle after accept, data_ok two cycles later
    access(4, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 0, 0, 32'h0,
           r_rdata, r_wstrb, r_wdata, r_size, r_wr);
    chk("pin_lw_rdata", r_rdata, 32'hDEAD_BEEF);
    idle(1);
    access(0, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 1, 1, 0, 0, 0, 32'h0,
           r_rdata, r_wstrb, r_wdata, r_size, r_wr);
    chk("pin_lb_rdata", r_rdata, 32'hFFFF_FF80);
    access(1, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 0, 0, 0, 32'h0,
           r_rdata, r_wstrb, r_wdata, r_size, r_wr);
    chk("pin_lbu_rdata", r_rdata, 32'h0000_0080);
    access(6, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 0, 0, 0, 0, 32'h0,
           r_rdata, r_wstrb, r_wdata, r_size, r_wr);
    chk("pin_sh_wstrb", r_wstrb, 4'b1100);
    chk("pin_sh_wdata", r_wdata, 32'hABCD_ABCD);
    chk("pin_sh_size", r_size, 2'd1);
    chk("pin_sh_wr", r_wr, 1'b1);
    chk("pin_sh_rdata_kept", r_rdata, 32'h0000_0080);

    // misaligned LW and SW
    mem_en = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h0000_3001;
    e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0;
    #1;
    chk("pin_adel", adelM, 1'b1);
    chk("pin_badv", badvaddrM, 32'h0000_3001);
    chk("pin_adel_noreq", bus_if.data_req, 1'b0);
    chk("pin_adel_nostall", stallM, 1'b0);
    step();
    alucontrolM = EXE_SW_OP; addrM = 32'h0000_3002;
    #1;
    chk("pin_ades", adesM, 1'b1);
    step();
    mem_en = 1'b0;
    idle(1);

    // flush during WAIT, new LW waits behind the drained response
    access(4, 32'h0000_4000, 32'h0, 32'h1111_1111, 0, 3, 0, 2, 1, 32'h0000_5004,
           r_rdata, r_wstrb, r_wdata, r_size, r_wr);
    access(4, 32'h0000_5004, 32'h0, 32'h2222_2222, 0, 1, 0, 0, 0, 32'h0,
           r_rdata, r_wstrb, r_wdata, r_size, r_wr);
    chk("pin_after_drain", r_rdata, 32'h2222_2222);

    // hold for 3 cycles in DONE, then reset during REQ
    access(3, 32'h0000_6002, 32'h0, 32'hBEEF_1234, 1, 1, 3, 0, 0, 32'h0,
           r_rdata, r_wstrb, r_wdata, r_size, r_wr);
    chk("pin_lhu_rdata", r_rdata, 32'h0000_BEEF);
    reset_in_req();

    for (int it = 0; it < 250; it++) begin
      oi = $urandom_range(0, 7);
      a  = $urandom_range(0, 2);
      d  = $urandom_range(0, 3);
      h  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      fmode = 0; fat = 0;
      r = $urandom_range(0, 9);
      if (r == 0 && a >= 1) begin fmode = 1; fat = $urandom_range(0, a - 1); end
      else if (r == 1 && d >= 2) begin fmode = 2; fat = $urandom_range(1, d - 1); end
      daddr = align_addr(4);
      access(oi, align_addr(oi), $urandom, $urandom, a, d, h, fmode, fat, daddr,
             r_rdata, r_wstrb, r_wdata, r_size, r_wr);
      if (fmode == 2)
        access(4, daddr, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
               0, 0, 0, 32'h0, r_rdata, r_wstrb, r_wdata, r_size, r_wr);
      if (it == 125) reset_in_req();
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
